// File: rtl/id_exe_stage_reg_pkg.sv
// Shared decode/execute definitions: condition codes, NZCV bit positions,
// ALU commands, instruction types and the control bundle carried down the pipe.
package id_exe_stage_reg_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   localparam int unsigned NZCV_N = 3;
   localparam int unsigned NZCV_Z = 2;
   localparam int unsigned NZCV_C = 1;
   localparam int unsigned NZCV_V = 0;

   typedef enum logic [3:0] {
      EXE_NOP = 4'b0000,
      EXE_MOV = 4'b0001,
      EXE_ADD = 4'b0010,
      EXE_ADC = 4'b0011,
      EXE_SUB = 4'b0100,
      EXE_SBC = 4'b0101,
      EXE_AND = 4'b0110,
      EXE_ORR = 4'b0111,
      EXE_EOR = 4'b1000,
      EXE_MVN = 4'b1001
   } alu_cmd_e;

   // Compare/test and load/store reuse the arithmetic encodings.
   localparam logic [3:0] EXE_CMP = EXE_SUB;
   localparam logic [3:0] EXE_TST = EXE_AND;
   localparam logic [3:0] EXE_LDR = EXE_ADD;
   localparam logic [3:0] EXE_STR = EXE_ADD;

   typedef enum logic [1:0] {
      INSTR_DP     = 2'b00,
      INSTR_MEM    = 2'b01,
      INSTR_BRANCH = 2'b10
   } instr_type_e;

   typedef struct packed {
      logic [3:0] exec_cmd;
      logic       mem_r_en;
      logic       mem_w_en;
      logic       wb_en;
      logic       status_w_en;
      logic       branch_taken;
      logic       imm;
   } ctrl_t;

endpackage

// File: rtl/id_exe_stage_reg_cond_check.sv
// Combinational ARM condition evaluation against the current NZCV flags.
module cond_check
   import id_exe_stage_reg_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] status_in,
   output logic       cond_pass
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = status_in[NZCV_N];
   assign w_z = status_in[NZCV_Z];
   assign w_c = status_in[NZCV_C];
   assign w_v = status_in[NZCV_V];

   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         COND_EQ: cond_pass = w_z;
         COND_NE: cond_pass = ~w_z;
         COND_CS: cond_pass = w_c;
         COND_CC: cond_pass = ~w_c;
         COND_MI: cond_pass = w_n;
         COND_PL: cond_pass = ~w_n;
         COND_VS: cond_pass = w_v;
         COND_VC: cond_pass = ~w_v;
         COND_HI: cond_pass = w_c & ~w_z;
         COND_LS: cond_pass = ~w_c | w_z;
         COND_GE: cond_pass = (w_n == w_v);
         COND_LT: cond_pass = (w_n != w_v);
         COND_GT: cond_pass = ~w_z & (w_n == w_v);
         COND_LE: cond_pass = w_z | (w_n != w_v);
         COND_AL: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: condition-gated control capture with freeze,
// flush, bubble insertion and a saturating bubble counter.
module id_exe_stage_reg
   import id_exe_stage_reg_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze,
   input  logic              flush,
   input  logic              hazard,
   input  logic [3:0]        cond,
   input  logic [3:0]        status_in,
   input  logic [3:0]        exec_cmd_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic              wb_en_in,
   input  logic              status_w_en_in,
   input  logic              branch_taken_in,
   input  logic              imm_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] val_rn_in,
   input  logic [DATA_W-1:0] val_rm_in,
   input  logic [11:0]       shift_operand_in,
   input  logic [23:0]       signed_imm24_in,
   input  logic [3:0]        dest_in,
   input  logic [3:0]        src1_in,
   input  logic [3:0]        src2_in,
   output logic [3:0]        exec_cmd,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              wb_en,
   output logic              status_w_en,
   output logic              branch_taken,
   output logic              imm,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] val_rn,
   output logic [DATA_W-1:0] val_rm,
   output logic [11:0]       shift_operand,
   output logic [23:0]       signed_imm24,
   output logic [3:0]        dest,
   output logic [3:0]        src1,
   output logic [3:0]        src2,
   output logic              valid,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic              w_cond_pass;
   logic              w_bubble;
   ctrl_t             w_ctrl_in;

   ctrl_t             r_ctrl;
   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] r_val_rn;
   logic [DATA_W-1:0] r_val_rm;
   logic [11:0]       r_shift_operand;
   logic [23:0]       r_signed_imm24;
   logic [3:0]        r_dest;
   logic [3:0]        r_src1;
   logic [3:0]        r_src2;
   logic              r_valid;
   logic [CNT_W-1:0]  r_bubble_cnt;

   cond_check u_cond_check (
      .cond      (cond),
      .status_in (status_in),
      .cond_pass (w_cond_pass)
   );

   assign w_bubble  = hazard | ~w_cond_pass;
   assign w_ctrl_in = '{exec_cmd:     exec_cmd_in,
                        mem_r_en:     mem_r_en_in,
                        mem_w_en:     mem_w_en_in,
                        wb_en:        wb_en_in,
                        status_w_en:  status_w_en_in,
                        branch_taken: branch_taken_in,
                        imm:          imm_in};

   // Control path: flush kills, bubble zeroes control, otherwise capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl       <= '0;
         r_valid      <= 1'b0;
         r_bubble_cnt <= '0;
      end else if (!freeze) begin
         if (flush) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
         end else if (w_bubble) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
            if (r_bubble_cnt != '1) begin
               r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
         end else begin
            r_ctrl  <= w_ctrl_in;
            r_valid <= 1'b1;
         end
      end
   end

   // Data path: only a flush clears it; bubbles still carry operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc            <= '0;
         r_val_rn        <= '0;
         r_val_rm        <= '0;
         r_shift_operand <= '0;
         r_signed_imm24  <= '0;
         r_dest          <= '0;
         r_src1          <= '0;
         r_src2          <= '0;
      end else if (!freeze) begin
         if (flush) begin
            r_pc            <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_shift_operand <= '0;
            r_signed_imm24  <= '0;
            r_dest          <= '0;
            r_src1          <= '0;
            r_src2          <= '0;
         end else begin
            r_pc            <= pc_in;
            r_val_rn        <= val_rn_in;
            r_val_rm        <= val_rm_in;
            r_shift_operand <= shift_operand_in;
            r_signed_imm24  <= signed_imm24_in;
            r_dest          <= dest_in;
            r_src1          <= src1_in;
            r_src2          <= src2_in;
         end
      end
   end

   assign exec_cmd      = r_ctrl.exec_cmd;
   assign mem_r_en      = r_ctrl.mem_r_en;
   assign mem_w_en      = r_ctrl.mem_w_en;
   assign wb_en         = r_ctrl.wb_en;
   assign status_w_en   = r_ctrl.status_w_en;
   assign branch_taken  = r_ctrl.branch_taken;
   assign imm           = r_ctrl.imm;
   assign pc            = r_pc;
   assign val_rn        = r_val_rn;
   assign val_rm        = r_val_rm;
   assign shift_operand = r_shift_operand;
   assign signed_imm24  = r_signed_imm24;
   assign dest          = r_dest;
   assign src1          = r_src1;
   assign src2          = r_src2;
   assign valid         = r_valid;
   assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed plus randomized bench for id_exe_stage_reg against an abstract model.
module tb_id_exe_stage_reg;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        freeze, flush, hazard;
   logic [3:0]  cond, status_in, exec_cmd_in;
   logic        mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, branch_taken_in, imm_in;
   logic [31:0] pc_in, val_rn_in, val_rm_in;
   logic [11:0] shift_operand_in;
   logic [23:0] signed_imm24_in;
   logic [3:0]  dest_in, src1_in, src2_in;

   logic [3:0]  exec_cmd;
   logic        mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, imm;
   logic [31:0] pc, val_rn, val_rm;
   logic [11:0] shift_operand;
   logic [23:0] signed_imm24;
   logic [3:0]  dest, src1, src2;
   logic        valid;
   logic [15:0] bubble_cnt;

   logic [3:0]  d4_exec_cmd;
   logic        d4_mem_r_en, d4_mem_w_en, d4_wb_en, d4_status_w_en, d4_branch_taken, d4_imm;
   logic [31:0] d4_pc, d4_val_rn, d4_val_rm;
   logic [11:0] d4_shift_operand;
   logic [23:0] d4_signed_imm24;
   logic [3:0]  d4_dest, d4_src1, d4_src2;
   logic        d4_valid;
   logic [3:0]  d4_bubble_cnt;

   int unsigned n_err = 0;
   int unsigned n_chk = 0;

   // Expected architectural contents of the EXE slot.
   logic [3:0]  e_exec;
   logic        e_mr, e_mw, e_wb, e_sw, e_br, e_imm;
   logic [31:0] e_pc, e_rn, e_rm;
   logic [11:0] e_sh;
   logic [23:0] e_i24;
   logic [3:0]  e_dest, e_s1, e_s2;
   logic        e_valid;
   int          e_cnt16, e_cnt4;

   always #5 clk = ~clk;

   id_exe_stage_reg dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .hazard(hazard),
      .cond(cond), .status_in(status_in), .exec_cmd_in(exec_cmd_in),
      .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
      .status_w_en_in(status_w_en_in), .branch_taken_in(branch_taken_in), .imm_in(imm_in),
      .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
      .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
      .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
      .exec_cmd(exec_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
      .status_w_en(status_w_en), .branch_taken(branch_taken), .imm(imm),
      .pc(pc), .val_rn(val_rn), .val_rm(val_rm), .shift_operand(shift_operand),
      .signed_imm24(signed_imm24), .dest(dest), .src1(src1), .src2(src2),
      .valid(valid), .bubble_cnt(bubble_cnt)
   );

   id_exe_stage_reg #(.DATA_W(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .hazard(hazard),
      .cond(cond), .status_in(status_in), .exec_cmd_in(exec_cmd_in),
      .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
      .status_w_en_in(status_w_en_in), .branch_taken_in(branch_taken_in), .imm_in(imm_in),
      .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
      .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
      .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
      .exec_cmd(d4_exec_cmd), .mem_r_en(d4_mem_r_en), .mem_w_en(d4_mem_w_en), .wb_en(d4_wb_en),
      .status_w_en(d4_status_w_en), .branch_taken(d4_branch_taken), .imm(d4_imm),
      .pc(d4_pc), .val_rn(d4_val_rn), .val_rm(d4_val_rm), .shift_operand(d4_shift_operand),
      .signed_imm24(d4_signed_imm24), .dest(d4_dest), .src1(d4_src1), .src2(d4_src2),
      .valid(d4_valid), .bubble_cnt(d4_bubble_cnt)
   );

   // ARM condition semantics stated directly from the flag meanings.
   function automatic bit holds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_clear();
      {e_exec, e_mr, e_mw, e_wb, e_sw, e_br, e_imm} = '0;
      {e_pc, e_rn, e_rm, e_sh, e_i24, e_dest, e_s1, e_s2} = '0;
      e_valid = 1'b0;
   endtask

   task automatic model_edge();
      if (freeze) return;
      if (flush) begin
         model_clear();
         return;
      end
      {e_pc, e_rn, e_rm, e_sh, e_i24} = {pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm24_in};
      {e_dest, e_s1, e_s2} = {dest_in, src1_in, src2_in};
      if (hazard || !holds(cond, status_in)) begin
         {e_exec, e_mr, e_mw, e_wb, e_sw, e_br, e_imm} = '0;
         e_valid = 1'b0;
         if (e_cnt16 < 65535) e_cnt16 = e_cnt16 + 1;
         if (e_cnt4 < 15) e_cnt4 = e_cnt4 + 1;
      end else begin
         {e_exec, e_mr, e_mw, e_wb, e_sw, e_br, e_imm} =
            {exec_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, branch_taken_in, imm_in};
         e_valid = 1'b1;
      end
   endtask

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("exec_cmd", 160'(exec_cmd), 160'(e_exec));
      chk("ctrl_bits", 160'({mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, imm}),
          160'({e_mr, e_mw, e_wb, e_sw, e_br, e_imm}));
      chk("pc", 160'(pc), 160'(e_pc));
      chk("val_rn", 160'(val_rn), 160'(e_rn));
      chk("val_rm", 160'(val_rm), 160'(e_rm));
      chk("shift_imm24", 160'({shift_operand, signed_imm24}), 160'({e_sh, e_i24}));
      chk("regs", 160'({dest, src1, src2}), 160'({e_dest, e_s1, e_s2}));
      chk("valid", 160'(valid), 160'(e_valid));
      chk("bubble_cnt", 160'(bubble_cnt), 160'(e_cnt16));
      chk("d4_bundle",
          160'({d4_exec_cmd, d4_mem_r_en, d4_mem_w_en, d4_wb_en, d4_status_w_en, d4_branch_taken,
                d4_imm, d4_pc, d4_val_rn, d4_val_rm, d4_shift_operand, d4_signed_imm24,
                d4_dest, d4_src1, d4_src2, d4_valid}),
          160'({e_exec, e_mr, e_mw, e_wb, e_sw, e_br, e_imm, e_pc, e_rn, e_rm, e_sh, e_i24,
                e_dest, e_s1, e_s2, e_valid}));
      chk("d4_bubble_cnt", 160'(d4_bubble_cnt), 160'(e_cnt4));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic rand_payload();
      exec_cmd_in      = 4'($urandom);
      {mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, branch_taken_in, imm_in} = 6'($urandom);
      pc_in            = $urandom;
      val_rn_in        = $urandom;
      val_rm_in        = $urandom;
      shift_operand_in = 12'($urandom);
      signed_imm24_in  = 24'($urandom);
      dest_in          = 4'($urandom);
      src1_in          = 4'($urandom);
      src2_in          = 4'($urandom);
      cond             = 4'($urandom);
      status_in        = 4'($urandom);
   endtask

   task automatic zero_payload();
      exec_cmd_in = '0;
      {mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, branch_taken_in, imm_in} = '0;
      {pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm24_in} = '0;
      {dest_in, src1_in, src2_in} = '0;
      cond = 4'b1110;
      status_in = '0;
   endtask

   initial begin
      freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
      rand_payload();
      e_cnt16 = 0; e_cnt4 = 0;
      model_clear();

      // Reset asserted with inputs driven: outputs clear before any edge.
      #1 rst_n = 1'b0;
      #1 check_all();
      @(negedge clk) rst_n = 1'b1;

      // Normal capture.
      zero_payload();
      cond = 4'b1110; wb_en_in = 1'b1; exec_cmd_in = 4'b0001; val_rn_in = 32'h5; dest_in = 4'd3;
      step();
      chk("cap_wb_en", 160'(wb_en), 160'(1));
      chk("cap_val_rn", 160'(val_rn), 160'(5));

      // EQ fails with Z=0, passes with Z=1.
      zero_payload();
      cond = 4'b0000; status_in = 4'b0000; mem_w_en_in = 1'b1;
      step();
      chk("eq_fail_cnt", 160'(bubble_cnt), 160'(1));
      status_in = 4'b0100;
      step();
      chk("eq_pass_mw", 160'(mem_w_en), 160'(1));

      // Freeze dominates flush and hazard.
      zero_payload();
      exec_cmd_in = 4'b0010; wb_en_in = 1'b1; val_rn_in = 32'h11; val_rm_in = 32'h22; dest_in = 4'd7;
      step();
      freeze = 1'b1; flush = 1'b1; hazard = 1'b1;
      rand_payload();
      for (int i = 0; i < 3; i++) step();
      chk("frz_valid", 160'(valid), 160'(1));
      freeze = 1'b0;
      step();
      chk("flush_valid", 160'(valid), 160'(0));

      // Flush over hazard, then reload and flush again.
      flush = 1'b0; hazard = 1'b0;
      zero_payload(); wb_en_in = 1'b1; pc_in = 32'h40;
      step();
      flush = 1'b1; hazard = 1'b1; rand_payload();
      step();
      flush = 1'b0;

      // Hazard held long enough to saturate the 4-bit counter.
      for (int i = 0; i < 20; i++) begin
         rand_payload();
         step();
      end
      chk("sat4", 160'(d4_bubble_cnt), 160'(15));
      hazard = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         rand_payload();
         freeze = ($urandom_range(0, 5) == 0);
         flush  = ($urandom_range(0, 7) == 0);
         hazard = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 2) == 0) cond = 4'b1110;
         step();
      end

      // Mid-cycle reset, then the first edge after release captures normally.
      freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
      zero_payload(); wb_en_in = 1'b1; val_rn_in = 32'hABCD;
      step();
      #2 rst_n = 1'b0;
      e_cnt16 = 0; e_cnt4 = 0;
      model_clear();
      #1 check_all();
      @(negedge clk) rst_n = 1'b1;
      zero_payload(); exec_cmd_in = 4'b0100; wb_en_in = 1'b1; dest_in = 4'd9; val_rm_in = 32'h77;
      step();
      chk("post_rst_valid", 160'(valid), 160'(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
